// File: rtl/logic_pkg.sv
// -----------------------------------------------------------------------------
// logic_pkg
// Shared definitions for the logic functional unit and its reservation station:
// opcode constants for the AND/OR/XOR family, the "no producer" tag value and
// the per-entry state encoding used by the reservation station.
// No ports (package).
// -----------------------------------------------------------------------------
package logic_pkg;

    localparam logic [2:0] LOP_AND  = 3'd0;
    localparam logic [2:0] LOP_OR   = 3'd1;
    localparam logic [2:0] LOP_XOR  = 3'd2;
    localparam logic [2:0] LOP_XNOR = 3'd3;
    localparam logic [2:0] LOP_NAND = 3'd4;
    localparam logic [2:0] LOP_NOR  = 3'd5;
    localparam logic [2:0] LOP_NOT  = 3'd6;
    localparam logic [2:0] LOP_PASS = 3'd7;

    // A producer tag of zero means the operand value is already present.
    localparam int TAG_NONE = 0;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } entry_state_t;

endpackage

// File: rtl/logic_rs_oldest_sel.sv
// -----------------------------------------------------------------------------
// logic_rs_oldest_sel
// Picks the oldest ready entry of the reservation station using an age matrix.
// older[i][j] = 1 means entry i was dispatched before entry j.
// Ports:
//   ready     in   N     entries that are ready to issue
//   older     in   NxN   age matrix
//   grant     out  N     one-hot grant of the oldest ready entry
//   any_ready out  1     at least one entry is ready
// -----------------------------------------------------------------------------
module logic_rs_oldest_sel #(
    parameter int N = 2
) (
    input  logic [N-1:0]           ready,
    input  logic [N-1:0][N-1:0]    older,
    output logic [N-1:0]           grant,
    output logic                   any_ready
);

    // An entry wins when it is ready and no other ready entry is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && ready[j] && older[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/logic_rs.sv
// -----------------------------------------------------------------------------
// logic_rs
// Reservation station for the Tomasulo logic functional unit. Holds dispatched
// instructions until both operands are available (captured from dispatch, the
// dispatch/CDB bypass, or a later CDB broadcast) and presents the oldest ready
// entry to the logic unit over a valid/ready handshake.
//
// Optional feature macro: LOGIC_RS_FLUSH_EN adds a FLUSH input that frees all
// entries at the clock edge and masks ISSUE_VALID while high.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   FLUSH                    (LOGIC_RS_FLUSH_EN only) free all entries
//   DISP_VALID/DISP_READY    dispatch handshake
//   DISP_OP, DISP_TAG        opcode and destination tag
//   DISP_Q1/Q2, DISP_V1/V2   operand producer tags (0 = ready) and values
//   CDB_VALID/TAG/DATA       common data bus broadcast
//   ISSUE_VALID/ISSUE_READY  issue handshake to the logic unit
//   ISSUE_OP/A/B/TAG         presented instruction
//   OCCUPANCY                number of busy entries
// -----------------------------------------------------------------------------
module logic_rs
    import logic_pkg::*;
#(
    parameter int NUM_ENTRIES = 2,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 4,
    parameter int OP_W        = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
`ifdef LOGIC_RS_FLUSH_EN
    input  logic                          FLUSH,
`endif
    input  logic                          DISP_VALID,
    output logic                          DISP_READY,
    input  logic [OP_W-1:0]               DISP_OP,
    input  logic [TAG_W-1:0]              DISP_TAG,
    input  logic [TAG_W-1:0]              DISP_Q1,
    input  logic [TAG_W-1:0]              DISP_Q2,
    input  logic [DATA_W-1:0]             DISP_V1,
    input  logic [DATA_W-1:0]             DISP_V2,
    input  logic                          CDB_VALID,
    input  logic [TAG_W-1:0]              CDB_TAG,
    input  logic [DATA_W-1:0]             CDB_DATA,
    output logic                          ISSUE_VALID,
    input  logic                          ISSUE_READY,
    output logic [OP_W-1:0]               ISSUE_OP,
    output logic [DATA_W-1:0]             ISSUE_A,
    output logic [DATA_W-1:0]             ISSUE_B,
    output logic [TAG_W-1:0]              ISSUE_TAG,
    output logic [$clog2(NUM_ENTRIES):0]  OCCUPANCY
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    entry_state_t        state_q [NUM_ENTRIES];
    entry_state_t        state_d [NUM_ENTRIES];
    logic [OP_W-1:0]     op_q    [NUM_ENTRIES];
    logic [OP_W-1:0]     op_d    [NUM_ENTRIES];
    logic [TAG_W-1:0]    tag_q   [NUM_ENTRIES];
    logic [TAG_W-1:0]    tag_d   [NUM_ENTRIES];
    logic [TAG_W-1:0]    q1_q    [NUM_ENTRIES];
    logic [TAG_W-1:0]    q1_d    [NUM_ENTRIES];
    logic [TAG_W-1:0]    q2_q    [NUM_ENTRIES];
    logic [TAG_W-1:0]    q2_d    [NUM_ENTRIES];
    logic [DATA_W-1:0]   v1_q    [NUM_ENTRIES];
    logic [DATA_W-1:0]   v1_d    [NUM_ENTRIES];
    logic [DATA_W-1:0]   v2_q    [NUM_ENTRIES];
    logic [DATA_W-1:0]   v2_d    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_d;

    logic                hold_q;
    logic                hold_d;
    logic [IDX_W-1:0]    hold_idx_q;
    logic [IDX_W-1:0]    hold_idx_d;

    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] ready_vec;
    logic [NUM_ENTRIES-1:0] grant;
    logic                   any_ready;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   alloc_found;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic                   disp_fire;
    logic                   issue_fire;

    logic [TAG_W-1:0]    byp_q1;
    logic [TAG_W-1:0]    byp_q2;
    logic [DATA_W-1:0]   byp_v1;
    logic [DATA_W-1:0]   byp_v2;

    // Decode registered entry states into free/ready vectors.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_vec[i]  = (state_q[i] == FREE);
            ready_vec[i] = (state_q[i] == READY);
        end
    end

    // Lowest-index free entry; scanning downwards leaves the lowest one.
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign DISP_READY = alloc_found & ~RST;
    assign disp_fire  = DISP_VALID & DISP_READY;

    logic_rs_oldest_sel #(
        .N (NUM_ENTRIES)
    ) u_oldest_sel (
        .ready     (ready_vec),
        .older     (older_q),
        .grant     (grant),
        .any_ready (any_ready)
    );

    // Encode the one-hot grant into an index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // A stalled presentation stays locked on its entry so that an older entry
    // waking up later cannot swap the operands out from under the logic unit.
    assign sel_idx = hold_q ? hold_idx_q : grant_idx;

`ifdef LOGIC_RS_FLUSH_EN
    assign ISSUE_VALID = any_ready & ~FLUSH;
`else
    assign ISSUE_VALID = any_ready;
`endif

    assign issue_fire = ISSUE_VALID & ISSUE_READY;

    // Issue data comes straight from the selected entry, zero when idle.
    always_comb begin
        ISSUE_OP  = '0;
        ISSUE_A   = '0;
        ISSUE_B   = '0;
        ISSUE_TAG = '0;
        if (ISSUE_VALID) begin
            ISSUE_OP  = op_q[sel_idx];
            ISSUE_A   = v1_q[sel_idx];
            ISSUE_B   = v2_q[sel_idx];
            ISSUE_TAG = tag_q[sel_idx];
        end
    end

    // Operands captured at dispatch, taking a same-cycle CDB broadcast
    // into account so the entry can be ready immediately.
    always_comb begin
        byp_q1 = DISP_Q1;
        byp_v1 = DISP_V1;
        byp_q2 = DISP_Q2;
        byp_v2 = DISP_V2;
        if (CDB_VALID && DISP_Q1 != NO_TAG && CDB_TAG == DISP_Q1) begin
            byp_q1 = NO_TAG;
            byp_v1 = CDB_DATA;
        end
        if (CDB_VALID && DISP_Q2 != NO_TAG && CDB_TAG == DISP_Q2) begin
            byp_q2 = NO_TAG;
            byp_v2 = CDB_DATA;
        end
    end

    // Next-state logic for every entry, the age matrix and the issue lock.
    always_comb begin
        older_d    = older_q;
        hold_d     = ISSUE_VALID & ~ISSUE_READY;
        hold_idx_d = sel_idx;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            tag_d[i]   = tag_q[i];
            q1_d[i]    = q1_q[i];
            q2_d[i]    = q2_q[i];
            v1_d[i]    = v1_q[i];
            v2_d[i]    = v2_q[i];
            case (state_q[i])
                FREE: begin
                    if (disp_fire && alloc_idx == IDX_W'(i)) begin
                        op_d[i]  = DISP_OP;
                        tag_d[i] = DISP_TAG;
                        q1_d[i]  = byp_q1;
                        q2_d[i]  = byp_q2;
                        v1_d[i]  = byp_v1;
                        v2_d[i]  = byp_v2;
                        state_d[i] = (byp_q1 == NO_TAG && byp_q2 == NO_TAG) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    if (CDB_VALID && q1_q[i] != NO_TAG && CDB_TAG == q1_q[i]) begin
                        q1_d[i] = NO_TAG;
                        v1_d[i] = CDB_DATA;
                    end
                    if (CDB_VALID && q2_q[i] != NO_TAG && CDB_TAG == q2_q[i]) begin
                        q2_d[i] = NO_TAG;
                        v2_d[i] = CDB_DATA;
                    end
                    if (q1_d[i] == NO_TAG && q2_d[i] == NO_TAG) begin
                        state_d[i] = READY;
                    end
                end
                READY: begin
                    if (issue_fire && sel_idx == IDX_W'(i)) begin
                        state_d[i] = FREE;
                    end
                end
                default: begin
                    state_d[i] = FREE;
                end
            endcase
        end
        // The new entry is younger than everything currently occupied.
        // Stale bits of free entries are harmless: a free entry is never
        // ready, and its row is cleared when it is allocated again.
        if (disp_fire) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                older_d[j][alloc_idx] = ~free_vec[j];
            end
            older_d[alloc_idx] = '0;
        end
`ifdef LOGIC_RS_FLUSH_EN
        // Flush overrides dispatch and CDB capture in the same cycle.
        if (FLUSH) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_d[i] = FREE;
            end
            older_d = '0;
            hold_d  = 1'b0;
        end
`endif
    end

    // State registers; reset empties the station immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= FREE;
                op_q[i]    <= '0;
                tag_q[i]   <= '0;
                q1_q[i]    <= '0;
                q2_q[i]    <= '0;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
            end
            older_q    <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                op_q[i]    <= op_d[i];
                tag_q[i]   <= tag_d[i];
                q1_q[i]    <= q1_d[i];
                q2_q[i]    <= q2_d[i];
                v1_q[i]    <= v1_d[i];
                v2_q[i]    <= v2_d[i];
            end
            older_q    <= older_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // Busy-entry count.
    always_comb begin
        OCCUPANCY = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!free_vec[i]) begin
                OCCUPANCY = OCCUPANCY + OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic_rs.sv
// -----------------------------------------------------------------------------
// tb_logic_rs
// Self-checking bench for logic_rs (two entries, 32-bit data, 4-bit tags).
// Expected issue transactions are queued when stimulus is applied and are
// popped by a monitor at every issue handshake. Directed checks cover reset,
// wake-up timing, stall holding, full/empty behaviour and mid-cycle reset.
// Define LOGIC_RS_FLUSH_EN to include the FLUSH scenario.
// -----------------------------------------------------------------------------
module tb_logic_rs;

    logic        CLK;
    logic        RST;
`ifdef LOGIC_RS_FLUSH_EN
    logic        FLUSH;
`endif
    logic        DISP_VALID;
    logic        DISP_READY;
    logic [2:0]  DISP_OP;
    logic [3:0]  DISP_TAG;
    logic [3:0]  DISP_Q1;
    logic [3:0]  DISP_Q2;
    logic [31:0] DISP_V1;
    logic [31:0] DISP_V2;
    logic        CDB_VALID;
    logic [3:0]  CDB_TAG;
    logic [31:0] CDB_DATA;
    logic        ISSUE_VALID;
    logic        ISSUE_READY;
    logic [2:0]  ISSUE_OP;
    logic [31:0] ISSUE_A;
    logic [31:0] ISSUE_B;
    logic [3:0]  ISSUE_TAG;
    logic [1:0]  OCCUPANCY;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic_rs #(
        .NUM_ENTRIES (2),
        .DATA_W      (32),
        .TAG_W       (4),
        .OP_W        (3)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
`ifdef LOGIC_RS_FLUSH_EN
        .FLUSH       (FLUSH),
`endif
        .DISP_VALID  (DISP_VALID),
        .DISP_READY  (DISP_READY),
        .DISP_OP     (DISP_OP),
        .DISP_TAG    (DISP_TAG),
        .DISP_Q1     (DISP_Q1),
        .DISP_Q2     (DISP_Q2),
        .DISP_V1     (DISP_V1),
        .DISP_V2     (DISP_V2),
        .CDB_VALID   (CDB_VALID),
        .CDB_TAG     (CDB_TAG),
        .CDB_DATA    (CDB_DATA),
        .ISSUE_VALID (ISSUE_VALID),
        .ISSUE_READY (ISSUE_READY),
        .ISSUE_OP    (ISSUE_OP),
        .ISSUE_A     (ISSUE_A),
        .ISSUE_B     (ISSUE_B),
        .ISSUE_TAG   (ISSUE_TAG),
        .OCCUPANCY   (OCCUPANCY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle of dispatch/CDB inputs, then return 1 ns after the edge.
    task automatic applyStimulus(input logic dv, input logic [2:0] op, input logic [3:0] tag,
                                 input logic [3:0] q1, input logic [3:0] q2,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic cv, input logic [3:0] ctag, input logic [31:0] cdata);
        DISP_VALID = dv;
        DISP_OP    = op;
        DISP_TAG   = tag;
        DISP_Q1    = q1;
        DISP_Q2    = q2;
        DISP_V1    = v1;
        DISP_V2    = v2;
        CDB_VALID  = cv;
        CDB_TAG    = ctag;
        CDB_DATA   = cdata;
        @(posedge CLK);
        #1;
        DISP_VALID = 1'b0;
        CDB_VALID  = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every issue handshake must match the queue head.
    always @(negedge CLK) begin
        if (!RST && ISSUE_VALID && ISSUE_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_issue: got tag %0d, expected no issue", ISSUE_TAG);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("issue_op",  32'(ISSUE_OP),  32'(e.op));
                checkOutput("issue_a",   ISSUE_A,        e.a);
                checkOutput("issue_b",   ISSUE_B,        e.b);
                checkOutput("issue_tag", 32'(ISSUE_TAG), 32'(e.tag));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST         = 1'b1;
`ifdef LOGIC_RS_FLUSH_EN
        FLUSH       = 1'b0;
`endif
        DISP_VALID  = 1'b0;
        DISP_OP     = '0;
        DISP_TAG    = '0;
        DISP_Q1     = '0;
        DISP_Q2     = '0;
        DISP_V1     = '0;
        DISP_V2     = '0;
        CDB_VALID   = 1'b0;
        CDB_TAG     = '0;
        CDB_DATA    = '0;
        ISSUE_READY = 1'b0;

        // Reset state
        idleCycle();
        idleCycle();
        checkOutput("rst_issue_valid", 32'(ISSUE_VALID), 32'd0);
        checkOutput("rst_occupancy",   32'(OCCUPANCY),   32'd0);
        checkOutput("rst_disp_ready",  32'(DISP_READY),  32'd0);
        checkOutput("rst_issue_a",     ISSUE_A,          32'd0);
        RST = 1'b0;
        #1;
        checkOutput("post_rst_disp_ready", 32'(DISP_READY), 32'd1);

        // Ready XNOR dispatch issues the following cycle
        $display("[TB] scenario 1: ready dispatch");
        ISSUE_READY = 1'b1;
        exp_q.push_back('{3'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd9});
        applyStimulus(1, 3'd3, 4'd9, 4'd0, 4'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 4'd0, 32'd0);
        checkOutput("s1_occupancy_1", 32'(OCCUPANCY),   32'd1);
        checkOutput("s1_issue_valid", 32'(ISSUE_VALID), 32'd1);
        idleCycle();
        checkOutput("s1_occupancy_0", 32'(OCCUPANCY),   32'd0);

        // Dispatch and issue in the same cycle keep occupancy constant
        exp_q.push_back('{3'd1, 32'h0000_0011, 32'h0000_0022, 4'd13});
        exp_q.push_back('{3'd2, 32'h0000_0033, 32'h0000_0044, 4'd14});
        applyStimulus(1, 3'd1, 4'd13, 4'd0, 4'd0, 32'h11, 32'h22, 0, 4'd0, 32'd0);
        checkOutput("s1b_occupancy_a", 32'(OCCUPANCY), 32'd1);
        applyStimulus(1, 3'd2, 4'd14, 4'd0, 4'd0, 32'h33, 32'h44, 0, 4'd0, 32'd0);
        checkOutput("s1b_occupancy_b", 32'(OCCUPANCY), 32'd1);
        checkOutput("s1b_issue_tag",   32'(ISSUE_TAG), 32'd14);
        idleCycle();
        checkOutput("s1b_occupancy_c", 32'(OCCUPANCY), 32'd0);

        // CDB wake-up: capture edge, then present one cycle later
        $display("[TB] scenario 2: CDB wake-up");
        exp_q.push_back('{3'd0, 32'h1234_5678, 32'h0000_FFFF, 4'd5});
        applyStimulus(1, 3'd0, 4'd5, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'h0000_FFFF, 0, 4'd0, 32'd0);
        checkOutput("s2_occupancy",     32'(OCCUPANCY),   32'd1);
        checkOutput("s2_wait_valid",    32'(ISSUE_VALID), 32'd0);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 1, 4'd4, 32'hBAD0_BAD0);
        checkOutput("s2_other_tag_valid", 32'(ISSUE_VALID), 32'd0);
        CDB_VALID = 1'b1;
        CDB_TAG   = 4'd3;
        CDB_DATA  = 32'h1234_5678;
        #1;
        checkOutput("s2_capture_cycle_valid", 32'(ISSUE_VALID), 32'd0);
        @(posedge CLK);
        #1;
        CDB_VALID = 1'b0;
        checkOutput("s2_woken_valid", 32'(ISSUE_VALID), 32'd1);
        checkOutput("s2_woken_a",     ISSUE_A,          32'h1234_5678);
        idleCycle();
        checkOutput("s2_occupancy_0", 32'(OCCUPANCY),   32'd0);

        // Dispatch/CDB bypass on both operands
        $display("[TB] scenario 3: dispatch bypass");
        exp_q.push_back('{3'd2, 32'h0000_00AA, 32'h0000_00AA, 4'd6});
        applyStimulus(1, 3'd2, 4'd6, 4'd7, 4'd7, 32'd0, 32'd0, 1, 4'd7, 32'h0000_00AA);
        checkOutput("s3_valid", 32'(ISSUE_VALID), 32'd1);
        checkOutput("s3_a",     ISSUE_A,          32'h0000_00AA);
        checkOutput("s3_b",     ISSUE_B,          32'h0000_00AA);
        idleCycle();
        checkOutput("s3_occupancy_0", 32'(OCCUPANCY), 32'd0);

        // Full station with a stalled logic unit
        $display("[TB] scenario 4: full and stalled");
        ISSUE_READY = 1'b0;
        exp_q.push_back('{3'd1, 32'h0000_0001, 32'h0000_0002, 4'd1});
        exp_q.push_back('{3'd4, 32'h0000_0003, 32'h0000_0004, 4'd2});
        applyStimulus(1, 3'd1, 4'd1, 4'd0, 4'd0, 32'd1, 32'd2, 0, 4'd0, 32'd0);
        applyStimulus(1, 3'd4, 4'd2, 4'd0, 4'd0, 32'd3, 32'd4, 0, 4'd0, 32'd0);
        checkOutput("s4_occupancy_full", 32'(OCCUPANCY),  32'd2);
        checkOutput("s4_disp_ready",     32'(DISP_READY), 32'd0);
        DISP_VALID = 1'b1;
        DISP_TAG   = 4'd11;
        DISP_Q1    = 4'd0;
        DISP_Q2    = 4'd0;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("s4_stall_tag",        32'(ISSUE_TAG),  32'd1);
            checkOutput("s4_stall_disp_ready", 32'(DISP_READY), 32'd0);
            checkOutput("s4_stall_occupancy",  32'(OCCUPANCY),  32'd2);
        end
        DISP_VALID  = 1'b0;
        ISSUE_READY = 1'b1;
        idleCycle();
        checkOutput("s4_second_tag", 32'(ISSUE_TAG), 32'd2);
        idleCycle();
        checkOutput("s4_occupancy_0", 32'(OCCUPANCY), 32'd0);

        // An older entry waking during a stall must not pre-empt it
        $display("[TB] scenario 4b: stall not pre-empted");
        ISSUE_READY = 1'b0;
        exp_q.push_back('{3'd6, 32'h0000_0020, 32'h0000_0030, 4'd2});
        exp_q.push_back('{3'd0, 32'h0000_0088, 32'h0000_0010, 4'd1});
        applyStimulus(1, 3'd0, 4'd1, 4'd8, 4'd0, 32'd0, 32'h10, 0, 4'd0, 32'd0);
        checkOutput("s4b_wait_valid", 32'(ISSUE_VALID), 32'd0);
        applyStimulus(1, 3'd6, 4'd2, 4'd0, 4'd0, 32'h20, 32'h30, 0, 4'd0, 32'd0);
        checkOutput("s4b_young_tag", 32'(ISSUE_TAG), 32'd2);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 1, 4'd8, 32'h88);
        checkOutput("s4b_held_tag_a", 32'(ISSUE_TAG), 32'd2);
        idleCycle();
        checkOutput("s4b_held_tag_b", 32'(ISSUE_TAG), 32'd2);
        ISSUE_READY = 1'b1;
        idleCycle();
        checkOutput("s4b_older_tag", 32'(ISSUE_TAG), 32'd1);
        idleCycle();
        checkOutput("s4b_occupancy_0", 32'(OCCUPANCY), 32'd0);

        // Asynchronous reset in the middle of a cycle
        $display("[TB] scenario 5: mid-cycle reset");
        ISSUE_READY = 1'b0;
        applyStimulus(1, 3'd5, 4'd3, 4'd0, 4'd0, 32'd7, 32'd8, 0, 4'd0, 32'd0);
        applyStimulus(1, 3'd5, 4'd4, 4'd0, 4'd0, 32'd9, 32'd10, 0, 4'd0, 32'd0);
        checkOutput("s5_occupancy_2", 32'(OCCUPANCY), 32'd2);
        #3;
        RST = 1'b1;
        #1;
        checkOutput("s5_rst_valid",     32'(ISSUE_VALID), 32'd0);
        checkOutput("s5_rst_occupancy", 32'(OCCUPANCY),   32'd0);
        checkOutput("s5_rst_disp_ready", 32'(DISP_READY), 32'd0);
        idleCycle();
        RST = 1'b0;
        #1;
        checkOutput("s5_release_disp_ready", 32'(DISP_READY),  32'd1);
        checkOutput("s5_release_valid",      32'(ISSUE_VALID), 32'd0);
        ISSUE_READY = 1'b1;
        idleCycle();

`ifdef LOGIC_RS_FLUSH_EN
        // Flush together with a matching broadcast
        $display("[TB] scenario 6: flush");
        applyStimulus(1, 3'd0, 4'd1, 4'd9, 4'd0, 32'd0, 32'd1, 0, 4'd0, 32'd0);
        applyStimulus(1, 3'd1, 4'd2, 4'd9, 4'd9, 32'd0, 32'd0, 0, 4'd0, 32'd0);
        checkOutput("s6_occupancy_2", 32'(OCCUPANCY), 32'd2);
        FLUSH     = 1'b1;
        CDB_VALID = 1'b1;
        CDB_TAG   = 4'd9;
        CDB_DATA  = 32'h5555_5555;
        #1;
        checkOutput("s6_flush_valid", 32'(ISSUE_VALID), 32'd0);
        @(posedge CLK);
        #1;
        FLUSH     = 1'b0;
        CDB_VALID = 1'b0;
        checkOutput("s6_occupancy_0", 32'(OCCUPANCY),   32'd0);
        checkOutput("s6_after_valid", 32'(ISSUE_VALID), 32'd0);
        idleCycle();
        checkOutput("s6_later_valid", 32'(ISSUE_VALID), 32'd0);
        checkOutput("s6_disp_ready",  32'(DISP_READY),  32'd1);
`endif

        idleCycle();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_rs.md
Name: logic_rs

Overview:
Reservation station for the Tomasulo logic functional unit (AND/OR/XOR/XNOR family).
- Accepts dispatched instructions whose operands may still be pending on producer tags.
- Snoops the common data bus (CDB) to capture those operands.
- Issues the oldest fully-ready entry to the combinational logic unit over a valid/ready handshake.
- Sits between the dispatch stage and the logic unit, on the initiator side of the logic unit's operand interface.

Parameters:
NUM_ENTRIES, 2, number of station entries (≥2).
DATA_W, 32, operand width.
TAG_W, 4, producer tag width; tag 0 = "value present, no wait".
OP_W, 3, logic opcode width.

Ports:
CLK  in  1  clock, all state on rising edge.
RST  in  1  asynchronous active-high reset.
DISP_VALID  in  1  dispatch request.
DISP_READY  out  1  a free entry exists.
DISP_OP  in  OP_W  logic opcode.
DISP_TAG  in  TAG_W  destination tag of this instruction.
DISP_Q1, DISP_Q2  in  TAG_W  operand producer tags (0 = ready).
DISP_V1, DISP_V2  in  DATA_W  operand values (valid when Qx=0).
CDB_VALID  in  1  CDB broadcast valid.
CDB_TAG  in  TAG_W  broadcast tag (never 0 when valid).
CDB_DATA  in  DATA_W  broadcast value.
ISSUE_VALID  out  1  a ready entry is presented.
ISSUE_READY  in  1  logic unit accepts.
ISSUE_OP  out  OP_W  opcode of presented entry.
ISSUE_A, ISSUE_B  out  DATA_W  operands.
ISSUE_TAG  out  TAG_W  destination tag.
OCCUPANCY  out  $clog2(NUM_ENTRIES)+1  number of busy entries.

Behaviour:
- Reset values: all entries FREE, age matrix cleared, ISSUE_VALID=0, ISSUE_* data=0, OCCUPANCY=0. DISP_READY is forced 0 while RST is high.
- Per-entry state machine, states FREE, WAIT, READY:
  - FREE→WAIT on dispatch if either captured tag is non-zero; FREE→READY if both are zero.
  - WAIT→READY at the clock edge where the last pending tag matches CDB.
  - READY→FREE on the issue handshake (ISSUE_VALID & ISSUE_READY).
- Dispatch:
  - Accepted when DISP_VALID & DISP_READY.
  - The lowest-index FREE entry is allocated.
  - DISP_READY reflects registered state only; an entry freed this cycle is allocatable next cycle.
- Dispatch/CDB bypass: if CDB_VALID and CDB_TAG equals a non-zero DISP_Qx in the same cycle, CDB_DATA is stored and Qx is cleared. The entry can enter READY directly.
- CDB capture: every WAIT entry compares both Qx with CDB_TAG. On a match it latches CDB_DATA and sets Qx=0. Both operands may match the same broadcast.
- Wake-up latency: an entry readied by the CDB at edge N presents ISSUE_VALID in the cycle after edge N, never in the capture cycle.
- Issue selection:
  - The oldest READY entry is chosen via an age matrix: older[i][j]=1 means i was dispatched before j.
  - On dispatch into entry k, set older[j][k]=1 for every occupied j and older[k][*]=0.
  - ISSUE_* outputs are combinational from the selected entry's registers.
  - The presented entry is held stable while ISSUE_VALID & !ISSUE_READY. A newly readied older entry must not pre-empt a stalled presentation.
- Simultaneous dispatch + issue: both take effect. OCCUPANCY is unchanged.
- Full: DISP_READY=0 and DISP_VALID is ignored.
- Empty: ISSUE_VALID=0.
- Reset mid-operation clears all entries immediately and asynchronously. In-flight dispatch and issue are dropped.

Optional Feature:
LOGIC_RS_FLUSH_EN
- Defined: adds input port FLUSH (1 bit). When FLUSH=1 at a clock edge, all entries go FREE and the age matrix clears; the flush has priority over dispatch and CDB capture that cycle. ISSUE_VALID is forced 0 combinationally while FLUSH=1.
- Undefined: no FLUSH port and no flush logic.

Decomposition:
- Shared package logic_pkg holds:
  - opcode constants: LOP_AND=0, LOP_OR=1, LOP_XOR=2, LOP_XNOR=3, LOP_NAND=4, LOP_NOR=5, LOP_NOT=6, LOP_PASS=7;
  - TAG_NONE=0;
  - entry state encoding FREE/WAIT/READY.
- One sub-module, logic_rs_oldest_sel: takes the ready vector and the age matrix and returns a one-hot grant plus an any-ready flag.

Test Plan:
1. Dispatch XNOR with Q1=Q2=0, V1=0xF0F0F0F0, V2=0x0F0F0F0F, ISSUE_READY=1 → ISSUE_VALID next cycle with ISSUE_A/B equal to the dispatched values, OP=3, TAG as dispatched; OCCUPANCY 1→0.
2. Dispatch tag 5 with Q1=3; later CDB tag 3 data 0x12345678 → entry READY the following cycle with ISSUE_A=0x12345678; no issue in the capture cycle.
3. Dispatch Q1=Q2=7 in the same cycle as CDB tag 7 data 0xAA → both operands 0xAA and ISSUE_VALID the next cycle (bypass).
4. Fill both entries (tags 1 then 2, both ready), ISSUE_READY=0 for 3 cycles → ISSUE_TAG stays 1, DISP_READY=0. Raise ISSUE_READY → issues tag 1, then tag 2.
5. Occupancy 2, hold ISSUE_READY=0, assert RST mid-cycle → ISSUE_VALID=0 and OCCUPANCY=0 immediately. After release, DISP_READY=1.
6. With LOGIC_RS_FLUSH_EN: two waiting entries, FLUSH=1 together with a matching CDB → all FREE next cycle and no issue.
